// File: rtl/img_core_pkg.sv
// Shared definitions for the img_proc_core accumulator processor:
// opcode map, FSM state encoding, ALU operation codes and decode helpers.
package img_core_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LDAC   = 4'h1;
    localparam logic [3:0] OP_STAC   = 4'h2;
    localparam logic [3:0] OP_MVMAR  = 4'h3;
    localparam logic [3:0] OP_MOVR   = 4'h4;
    localparam logic [3:0] OP_MOVA   = 4'h5;
    localparam logic [3:0] OP_ADD    = 4'h6;
    localparam logic [3:0] OP_SUB    = 4'h7;
    localparam logic [3:0] OP_INCR   = 4'h8;
    localparam logic [3:0] OP_INCMAR = 4'h9;
    localparam logic [3:0] OP_CLAC   = 4'hA;
    localparam logic [3:0] OP_JMPZ   = 4'hB;
    localparam logic [3:0] OP_JMP    = 4'hC;
    localparam logic [3:0] OP_SHR    = 4'hD;
    localparam logic [3:0] OP_LDI    = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_OPND  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_INC,
        ALU_SHR,
        ALU_ZERO
    } alu_op_t;

    function automatic logic is_two_byte(input logic [3:0] opc);
        return (opc == OP_JMPZ) || (opc == OP_JMP) || (opc == OP_LDI);
    endfunction

    function automatic logic is_mem(input logic [3:0] opc);
        return (opc == OP_LDAC) || (opc == OP_STAC);
    endfunction

endpackage

// File: rtl/img_core_alu.sv
// Combinational ALU for img_proc_core.
// Build option SAT_ARITH_EN: ADD clamps high, SUB clamps at zero.
module img_core_alu
    import img_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        shamt,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    logic [DATA_W-1:0] add_y;
    logic [DATA_W-1:0] sub_y;

`ifdef SAT_ARITH_EN
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    // Carry-out on add / borrow on subtract selects the pixel clamp value.
    assign add_y = sum[DATA_W]  ? '1 : sum[DATA_W-1:0];
    assign sub_y = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
    assign add_y = a + b;
    assign sub_y = a - b;
`endif

    always_comb begin
        y = '0;
        case (op)
            ALU_PASS: y = b;
            ALU_ADD:  y = add_y;
            ALU_SUB:  y = sub_y;
            ALU_INC:  y = a + DATA_W'(1);
            ALU_SHR:  y = a >> shamt;
            ALU_ZERO: y = '0;
            default:  y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/img_proc_core.sv
// Multi-cycle accumulator processor core: FSM, GP registers, PC, MAR
// and req/ack data-memory handshake. Build option SAT_ARITH_EN (see ALU).
module img_proc_core
    import img_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_GP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              z_flag,
    output logic              halted,
    output logic [DATA_W-1:0] ac_out
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ac;
    logic              z;
    logic [7:0]        ir;
    logic [7:0]        op;
    logic [DATA_W-1:0] regs [NUM_GP];

    logic [3:0]        opc;
    logic [3:0]        opr;
    logic [3:0]        nopc;
    logic [DATA_W-1:0] rd;
    logic              in_exec;
    logic              mem_ack;

    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zero;
    logic              ac_we;

    assign opc     = ir[7:4];
    assign opr     = ir[3:0];
    assign nopc    = imem_data[7:4];
    assign in_exec = (state == S_EXEC);
    assign mem_ack = (state == S_MEM) && dmem_ack;

    // Register indices at or above NUM_GP read as zero.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_GP; i++) begin
            if (opr == 4'(i)) rd = regs[i];
        end
    end

    always_comb begin
        alu_op = ALU_PASS;
        alu_a  = ac;
        alu_b  = rd;
        ac_we  = 1'b0;
        case (opc)
            OP_LDAC: begin
                alu_b = dmem_rdata;
                ac_we = mem_ack;
            end
            OP_MOVA: ac_we = in_exec;
            OP_ADD: begin
                alu_op = ALU_ADD;
                ac_we  = in_exec;
            end
            OP_SUB: begin
                alu_op = ALU_SUB;
                ac_we  = in_exec;
            end
            OP_INCR: begin
                alu_op = ALU_INC;
                alu_a  = rd;
            end
            OP_CLAC: begin
                alu_op = ALU_ZERO;
                ac_we  = in_exec;
            end
            OP_SHR: begin
                alu_op = ALU_SHR;
                ac_we  = in_exec;
            end
            OP_LDI: begin
                alu_b = DATA_W'(op);
                ac_we = in_exec;
            end
            default: ;
        endcase
    end

    img_core_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op   (alu_op),
        .a    (alu_a),
        .b    (alu_b),
        .shamt(opr),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= '0;
            mar   <= '0;
            ir    <= '0;
            op    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= imem_data;
                    pc <= pc + ADDR_W'(1);
                    unique case (1'b1)
                        is_two_byte(nopc): state <= S_OPND;
                        is_mem(nopc):      state <= S_MEM;
                        default:           state <= S_EXEC;
                    endcase
                end
                S_OPND: begin
                    op    <= imem_data;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= (opc == OP_HALT) ? S_HALT : S_FETCH;
                    case (opc)
                        OP_MVMAR:  mar <= rd[ADDR_W-1:0];
                        OP_INCMAR: mar <= mar + ADDR_W'(1);
                        OP_JMPZ:   if (z) pc <= ADDR_W'(op);
                        OP_JMP:    pc <= ADDR_W'(op);
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) state <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac <= '0;
            z  <= 1'b1;
        end else if (ac_we) begin
            ac <= alu_y;
            z  <= alu_zero;
        end
    end

    // Writes to indices at or above NUM_GP match no register and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GP; i++) regs[i] <= '0;
        end else if (in_exec) begin
            for (int i = 0; i < NUM_GP; i++) begin
                if (opr == 4'(i)) begin
                    if (opc == OP_MOVR) regs[i] <= ac;
                    else if (opc == OP_INCR) regs[i] <= alu_y;
                end
            end
        end
    end

    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = dmem_req && (opc == OP_STAC);
    assign dmem_addr  = mar;
    assign dmem_wdata = ac;
    assign z_flag     = z;
    assign halted     = (state == S_HALT);
    assign ac_out     = ac;

endmodule
